// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: read-mode constants and depth helper shared by the FIFO files
package sync_fifo_pkg;
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;
    function automatic int fifo_depth(input int addrwidth);
        return 1 << addrwidth;
    endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: 2**ADDRWIDTH x DWIDTH storage, one clocked write port, one combinational read port, no reset
// ports: clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port
module sync_fifo_ram import sync_fifo_pkg::*; #(
    parameter int DWIDTH    = 8,
    parameter int ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDRWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0]    i_wdata,
    input  logic [ADDRWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0]    o_rdata
);
    logic [DWIDTH-1:0] r_mem [0:fifo_depth(ADDRWIDTH)-1];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered flags, sticky errors and selectable registered/FWFT read
// ports: clk, rst (sync, active high); w_enable/wdata push; r_enable pop; clr_err clears sticky errors;
//        rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
module sync_fifo import sync_fifo_pkg::*; #(
    parameter int DWIDTH    = 8,
    parameter int ADDRWIDTH = 9,
    parameter int AF_THRESH = fifo_depth(ADDRWIDTH) - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_enable,
    input  logic [DWIDTH-1:0]    wdata,
    input  logic                 r_enable,
    input  logic                 clr_err,
    output logic [DWIDTH-1:0]    rdata,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDRWIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic [ADDRWIDTH:0] DEPTH = (ADDRWIDTH+1)'(fifo_depth(ADDRWIDTH));
    localparam logic [ADDRWIDTH:0] AF    = (ADDRWIDTH+1)'(AF_THRESH);
    localparam logic [ADDRWIDTH:0] AE    = (ADDRWIDTH+1)'(AE_THRESH);

    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= fifo_depth(ADDRWIDTH))) begin : g_bad_thresh
        $error("sync_fifo: need AE_THRESH < AF_THRESH <= depth");
    end

    logic [ADDRWIDTH-1:0] r_wptr, r_rptr;
    logic [ADDRWIDTH:0]   r_count;
    logic                 r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic [DWIDTH-1:0]    r_rdata;
    logic                 w_wr, w_rd;
    logic [ADDRWIDTH:0]   w_count_nxt;
    logic [DWIDTH-1:0]    w_ram_q;

    // full is the registered flag, so a read while full cannot make room for a same-cycle write
    assign w_wr        = w_enable && !r_full;
    assign w_rd        = r_enable && !r_empty;
    assign w_count_nxt = r_count + (ADDRWIDTH+1)'(w_wr) - (ADDRWIDTH+1)'(w_rd);

    sync_fifo_ram #(.DWIDTH(DWIDTH), .ADDRWIDTH(ADDRWIDTH)) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wptr),
        .i_wdata (wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_wptr  <= r_wptr + ADDRWIDTH'(w_wr);
            r_rptr  <= r_rptr + ADDRWIDTH'(w_rd);
            r_count <= w_count_nxt;
            r_full  <= w_count_nxt == DEPTH;
            r_empty <= w_count_nxt == '0;
            r_af    <= w_count_nxt >= AF;
            r_ae    <= w_count_nxt <= AE;
            // a new error wins over a simultaneous clear
            r_ovf   <= (w_enable && r_full) || (r_ovf && !clr_err);
            r_unf   <= (r_enable && r_empty) || (r_unf && !clr_err);
            if (w_rd) r_rdata <= w_ram_q;
        end
    end

    // in FWFT mode the head word is shown directly; once drained the last popped word is held
    assign rdata        = (FWFT == FWFT_ON && !r_empty) ? w_ram_q : r_rdata;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: random and directed stimulus on registered and FWFT instances against a queue model
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_enable = 1'b0;
    logic [7:0] wdata = '0;
    logic       r_enable = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rdata0, rdata1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] last_rd = '0;
    logic       m_ovf = 1'b0, m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.DWIDTH(8), .ADDRWIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .w_enable(w_enable), .wdata(wdata), .r_enable(r_enable), .clr_err(clr_err),
        .rdata(rdata0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo #(.DWIDTH(8), .ADDRWIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .w_enable(w_enable), .wdata(wdata), .r_enable(r_enable), .clr_err(clr_err),
        .rdata(rdata1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        check("count0", 32'(count0), 32'(n));
        check("count1", 32'(count1), 32'(n));
        check("full0", 32'(full0), 32'(n == 16));
        check("full1", 32'(full1), 32'(n == 16));
        check("empty0", 32'(empty0), 32'(n == 0));
        check("empty1", 32'(empty1), 32'(n == 0));
        check("af0", 32'(af0), 32'(n >= 14));
        check("af1", 32'(af1), 32'(n >= 14));
        check("ae0", 32'(ae0), 32'(n <= 2));
        check("ae1", 32'(ae1), 32'(n <= 2));
        check("ovf0", 32'(ovf0), 32'(m_ovf));
        check("ovf1", 32'(ovf1), 32'(m_ovf));
        check("unf0", 32'(unf0), 32'(m_unf));
        check("unf1", 32'(unf1), 32'(m_unf));
        check("rdata0", 32'(rdata0), 32'(last_rd));
        check("rdata1", 32'(rdata1), 32'(n > 0 ? q[0] : last_rd));
    endtask

    task automatic cycle(input logic we, input logic [7:0] d, input logic re, input logic ce, input logic rs);
        int n;
        w_enable = we;
        wdata    = d;
        r_enable = re;
        clr_err  = ce;
        rst      = rs;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            last_rd = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            m_ovf = (we && n == 16) || (m_ovf && !ce);
            m_unf = (re && n == 0) || (m_unf && !ce);
            if (re && n > 0) last_rd = q.pop_front();
            if (we && n < 16) q.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h9A, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h9B, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 60; i++) begin
                logic we, re;
                we = $urandom_range(99) < ((p % 2 == 0) ? 75 : 25);
                re = $urandom_range(99) < ((p % 2 == 0) ? 25 : 75);
                cycle(we, 8'($urandom), re, $urandom_range(19) == 0, $urandom_range(149) == 0);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDRWIDTH, default 9, address width; depth = 2**ADDRWIDTH entries.
REQ-003 Parameter AF_THRESH, default 2**ADDRWIDTH-4, almost_full assertion level (entries).
REQ-004 Parameter AE_THRESH, default 4, almost_empty assertion level (entries).
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 w_enable  input  1  write request.
REQ-009 wdata  input  DWIDTH  write data.
REQ-010 r_enable  input  1  read (pop) request.
REQ-011 clr_err  input  1  clears sticky error flags.
REQ-012 rdata  output  DWIDTH  read data.
REQ-013 full, empty  output  1 each  occupancy = depth / occupancy = 0.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 count  output  ADDRWIDTH+1  current occupancy, 0..depth.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 A write is accepted iff w_enable && !full; the word is stored at the write pointer, which then increments modulo depth.
REQ-018 A read is accepted iff r_enable && !empty; the read pointer then increments modulo depth.
REQ-019 Simultaneous accepted read and write: both pointers advance, count unchanged; a read when full frees a slot only from the next cycle (no write-through when full).
REQ-020 count, full, empty, almost_full, almost_empty are registered and reflect all accepted operations one cycle after the edge that accepts them.
REQ-021 almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH).
REQ-022 FWFT=0: rdata updates on the edge after an accepted read (1-cycle latency) and holds its last value otherwise (never high-impedance).
REQ-023 FWFT=1: rdata presents the head word whenever empty=0; an accepted read exposes the next word in the following cycle; a word written into an empty FIFO is visible with empty=0 one cycle after its write.
REQ-024 overflow sets on any cycle with w_enable && full; underflow sets on any cycle with r_enable && empty; both hold until clr_err or rst.
REQ-025 clr_err and a new error in the same cycle: the flag remains set.
REQ-026 Rejected operations leave pointers, count, memory and rdata unchanged.
REQ-027 Pointer wrap from depth-1 to 0 is seamless; full/empty are derived from count, not pointer equality alone.

Reset
REQ-028 On rst=1 at a clock edge: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rdata=0, overflow=0, underflow=0.
REQ-029 rst overrides simultaneous w_enable/r_enable; memory contents are not reset and are unreachable until rewritten.
REQ-030 rst asserted mid-operation discards all stored words; first access after release behaves as from an empty FIFO.

Structure
REQ-031 Package sync_fifo_pkg holds mode constants (FWFT_OFF, FWFT_ON) and a function computing depth from ADDRWIDTH.
REQ-032 Storage is one sub-module sync_fifo_ram: 2**ADDRWIDTH x DWIDTH, one write port, one read port, same clock, no reset.
REQ-033 Parameter checks: AE_THRESH < AF_THRESH <= depth, else elaboration error.

Verification (DWIDTH=8, ADDRWIDTH=4, AF_THRESH=14, AE_THRESH=2)
REQ-034 Reset, then write 0x01..0x10 (16 words) -> full=1 after 16th, almost_full=1 once count=14, count=16; 17th write -> overflow=1, contents unchanged.
REQ-035 Read 16 words, FWFT=0 -> rdata 0x01..0x10 each one cycle after its read; empty=1 after last; extra read -> underflow=1, rdata holds 0x10.
REQ-036 Fill 8, then 20 cycles of simultaneous read+write -> count stays 8, data order preserved across pointer wrap.
REQ-037 FWFT=1: write 0xA5 to empty FIFO -> next cycle empty=0, rdata=0xA5 without r_enable; read -> empty=1.
REQ-038 Fill 10, assert rst for one cycle with w_enable=1 -> count=0, empty=1, flags cleared; next read of returned data shows only words written after reset.
REQ-039 Set overflow, assert clr_err with w_enable=0 -> overflow=0 next cycle; clr_err with w_enable=1 while full -> overflow stays 1.
